// File: rtl/i3c_pkg.sv
// Shared I3C types and constants for the target-side SDR receive path.
package i3c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    TBIT,
    WAIT_STOP
  } i3c_tgt_rx_state_e;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

endpackage

// File: rtl/i3c_bus_cond_det.sv
// SCL/SDA synchroniser with SCL edge strobes and START/STOP strobes.
module i3c_bus_cond_det #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  scl_s, sda_s;

  // Reset to the idle-bus level so leaving reset produces no false edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SyncStages-1];
  assign sda_s      = sda_sync_q[SyncStages-1];
  assign sda_lvl_o  = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be stably high across the SDA transition.
  assign start_o    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_o     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

endmodule

// File: rtl/i3c_target_sdr_rx.sv
// I3C target SDR receiver: header match/ACK, T-bit checked write bytes on a valid/ready stream.
module i3c_target_sdr_rx
  import i3c_pkg::*;
#(
  parameter int         SyncStages = 2,
  parameter logic [6:0] BcastAddr  = I3C_BCAST_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [6:0] static_addr_i,
  input  logic [6:0] dyn_addr_i,
  input  logic       dyn_addr_valid_i,
  output logic [7:0] rx_data_o,
  output logic       rx_bcast_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       start_det_o,
  output logic       stop_det_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  logic scl_rise, scl_fall, sda_lvl, start_stb, stop_stb;

  i3c_bus_cond_det #(.SyncStages(SyncStages)) u_cond (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_lvl_o  (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_stb),
    .stop_o     (stop_stb)
  );

  i3c_tgt_rx_state_e state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       bcast_q, bcast_d, sda_q, sda_d;
  logic       rx_bcast_q, rx_bcast_d, rx_valid_q, rx_valid_d;
  logic       start_q, start_d, stop_q, stop_d, perr_q, perr_d, ovf_q, ovf_d;
  logic       load_q, load_d;
  logic [6:0] act_addr;
  logic       hdr_match;

  assign act_addr  = dyn_addr_valid_i ? dyn_addr_i : static_addr_i;
  assign hdr_match = ~shift_q[0] & ((shift_q[7:1] == act_addr) | (shift_q[7:1] == BcastAddr));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      bcast_q    <= 1'b0;
      sda_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_bcast_q <= 1'b0;
      rx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      bcast_q    <= bcast_d;
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_bcast_q <= rx_bcast_d;
      rx_valid_q <= rx_valid_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
      load_q     <= load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    bcast_d    = bcast_q;
    sda_d      = sda_q;
    rx_data_d  = rx_data_q;
    rx_bcast_d = rx_bcast_q;
    rx_valid_d = rx_valid_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    perr_d     = 1'b0;
    ovf_d      = 1'b0;
    load_d     = 1'b0;

    // Output stream runs independently of the bus FSM and of enable_i.
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (load_q) begin
      if (rx_valid_q && !rx_ready_i) begin
        ovf_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_bcast_d = bcast_q;
        rx_valid_d = 1'b1;
      end
    end

    if (!enable_i) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_d    = 1'b1;
    end else if (stop_stb) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_d    = 1'b1;
      stop_d   = 1'b1;
    end else if (start_stb) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_d    = 1'b1;
      start_d  = 1'b1;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + 4'd1;
          end
          if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (hdr_match) begin
              state_d = ADDR_ACK;
              sda_d   = 1'b0;
              bcast_d = (shift_q[7:1] == BcastAddr);
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = DATA;
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) state_d = TBIT;
          end
        end
        TBIT: begin
          // T is not shifted in, so shift_q still holds the byte for the load cycle.
          if (scl_rise) begin
            bitcnt_d = '0;
            if (^{shift_q, sda_lvl}) begin
              load_d  = 1'b1;
              state_d = DATA;
            end else begin
              perr_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_o        = sda_q;
  assign rx_data_o    = rx_data_q;
  assign rx_bcast_o   = rx_bcast_q;
  assign rx_valid_o   = rx_valid_q;
  assign start_det_o  = start_q;
  assign stop_det_o   = stop_q;
  assign parity_err_o = perr_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_i3c_target_sdr_rx.sv
// Directed bench for i3c_target_sdr_rx: table of single-byte frames plus multi-cycle corner sequences.
module tb_i3c_target_sdr_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic       sda_bus;
  logic       sda_o;
  logic [6:0] static_addr = 7'h5A;
  logic [6:0] dyn_addr = 7'h10;
  logic       dyn_valid = 1'b0;
  logic [7:0] rx_data;
  logic       rx_bcast, rx_valid;
  logic       rx_ready = 1'b0;
  logic       start_det, stop_det, parity_err, overflow, busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0, n_stop = 0, n_perr = 0, n_ovf = 0;

  // Open-drain wired-AND of controller and target drive.
  assign sda_bus = tb_sda & sda_o;

  always #5 clk = ~clk;

  i3c_target_sdr_rx dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .scl_i            (scl),
    .sda_i            (sda_bus),
    .sda_o            (sda_o),
    .static_addr_i    (static_addr),
    .dyn_addr_i       (dyn_addr),
    .dyn_addr_valid_i (dyn_valid),
    .rx_data_o        (rx_data),
    .rx_bcast_o       (rx_bcast),
    .rx_valid_o       (rx_valid),
    .rx_ready_i       (rx_ready),
    .start_det_o      (start_det),
    .stop_det_o       (stop_det),
    .parity_err_o     (parity_err),
    .overflow_o       (overflow),
    .busy_o           (busy)
  );

  always @(negedge clk) begin
    if (start_det)  n_start++;
    if (stop_det)   n_stop++;
    if (parity_err) n_perr++;
    if (overflow)   n_ovf++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends with SCL low; returns sda_o sampled mid SCL-high.
  task automatic send_bit(input logic b, output logic smp);
    tb_sda = b;  wclk(4);
    scl = 1'b1;  wclk(4);
    smp = sda_o; wclk(4);
    scl = 1'b0;  wclk(4);
  endtask

  task automatic bus_start();
    scl = 1'b1; tb_sda = 1'b1; wclk(8);
    tb_sda = 1'b0; wclk(8);
    scl = 1'b0; wclk(4);
  endtask

  task automatic bus_rstart();
    tb_sda = 1'b1; wclk(4);
    scl = 1'b1;    wclk(8);
    tb_sda = 1'b0; wclk(8);
    scl = 1'b0;    wclk(4);
  endtask

  task automatic bus_stop();
    tb_sda = 1'b0; wclk(4);
    scl = 1'b1;    wclk(8);
    tb_sda = 1'b1; wclk(8);
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
  endtask

  // Header byte plus the ACK slot; ack=1 when sda_o is low across the 9th clock.
  task automatic send_hdr(input logic [6:0] a, input logic rnw, output logic ack);
    logic s;
    send_byte({a, rnw});
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic send_data(input logic [7:0] d, input logic t);
    logic s;
    send_byte(d);
    send_bit(t, s);
  endtask

  task automatic accept();
    rx_ready = 1'b1; wclk(1);
    rx_ready = 1'b0; wclk(1);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rnw;
    logic [7:0] data;
    logic       tbit;
    logic       use_dyn;
    logic       exp_ack;
    logic       exp_valid;
    logic       exp_bcast;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic ack;
    int   s_start, s_stop, s_perr, s_ovf;

    //          addr   rnw  data   T    dyn  ack  vld  bc   perr
    vecs[0] = '{7'h5A, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'h7E, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{7'h5A, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{7'h10, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{7'h10, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7'h5A, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{7'h7E, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{7'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{7'h10, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    wclk(3);
    chk("rst_sda", sda_o, 1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {start_det, stop_det, parity_err, overflow, rx_bcast}, 0);
    rst = 1'b0;
    wclk(4);

    for (int v = 0; v < 9; v++) begin
      dyn_valid = vecs[v].use_dyn;
      s_start = n_start; s_stop = n_stop; s_perr = n_perr;
      bus_start();
      send_hdr(vecs[v].addr, vecs[v].rnw, ack);
      send_data(vecs[v].data, vecs[v].tbit);
      bus_stop();
      wclk(4);
      chk($sformatf("v%0d_ack", v), ack, vecs[v].exp_ack);
      chk($sformatf("v%0d_valid", v), rx_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        chk($sformatf("v%0d_data", v), rx_data, vecs[v].data);
        chk($sformatf("v%0d_bcast", v), rx_bcast, vecs[v].exp_bcast);
      end
      chk($sformatf("v%0d_perr", v), n_perr - s_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d_start", v), n_start - s_start, 1);
      chk($sformatf("v%0d_stop", v), n_stop - s_stop, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_sda", v), sda_o, 1);
      accept();
      chk($sformatf("v%0d_clr", v), rx_valid, 0);
    end
    dyn_valid = 1'b0;

    // Bad T bit: later bytes are ignored until STOP.
    s_perr = n_perr;
    bus_start();
    send_hdr(7'h5A, 1'b0, ack);
    send_data(8'h3C, 1'b0);
    chk("pe_busy", busy, 1);
    send_data(8'h81, 1'b1);
    bus_stop();
    wclk(4);
    chk("pe_ack", ack, 1);
    chk("pe_count", n_perr - s_perr, 1);
    chk("pe_valid", rx_valid, 0);
    chk("pe_busy_end", busy, 0);

    // Overflow with consumer stalled, then Sr mid-byte back to ADDR.
    s_ovf = n_ovf; s_start = n_start;
    bus_start();
    send_hdr(7'h5A, 1'b0, ack);
    send_data(8'h11, 1'b1);
    send_data(8'h22, 1'b1);
    wclk(2);
    chk("ov_count", n_ovf - s_ovf, 1);
    chk("ov_data", rx_data, 8'h11);
    chk("ov_valid", rx_valid, 1);
    begin
      logic s;
      send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    end
    bus_rstart();
    send_hdr(7'h5A, 1'b0, ack);
    chk("sr_ack", ack, 1);
    bus_stop();
    wclk(4);
    chk("sr_starts", n_start - s_start, 2);
    chk("sr_data", rx_data, 8'h11);
    chk("sr_busy", busy, 0);
    accept();
    chk("ov_clr", rx_valid, 0);

    // enable_i low during ACK releases SDA and forces IDLE.
    bus_start();
    send_byte({7'h5A, 1'b0});
    wclk(2);
    chk("en_ack_drive", sda_o, 0);
    enable = 1'b0;
    wclk(2);
    chk("en_sda", sda_o, 1);
    chk("en_busy", busy, 0);
    enable = 1'b1;
    bus_stop();
    wclk(4);

    // Reset during ACK releases SDA asynchronously; a fresh frame then works.
    bus_start();
    send_byte({7'h5A, 1'b0});
    wclk(2);
    chk("ra_drive", sda_o, 0);
    chk("ra_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("ra_sda", sda_o, 1);
    chk("ra_busy0", busy, 0);
    wclk(2);
    rst = 1'b0;
    scl = 1'b1; tb_sda = 1'b1;
    wclk(8);
    bus_start();
    send_hdr(7'h5A, 1'b0, ack);
    send_data(8'h42, 1'b1);
    bus_stop();
    wclk(4);
    chk("rf_ack", ack, 1);
    chk("rf_valid", rx_valid, 1);
    chk("rf_data", rx_data, 8'h42);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
